// File: rtl/trace_collector.sv
// Writeback trace collector: buffers qualifying register-write events in a FIFO
// and serializes each 72-bit record as nine bytes over a valid/ready stream.
module trace_collector #(
    parameter int DEPTH       = 8,
    parameter bit FILTER_ZERO = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     debug_reg_write_en,
    input  logic [4:0]               debug_reg_write_addr,
    input  logic [31:0]              debug_reg_write_data,
    input  logic [31:0]              debug_pc_addr,
    output logic                     out_valid,
    output logic [7:0]               out_data,
    input  logic                     out_ready,
    output logic                     overflow,
    output logic [15:0]              drop_count,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FIFO_FULL = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE   = 1;
    localparam logic [AW-1:0] PTR_ONE   = 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [71:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [0:0]    state;
    logic [71:0]   shreg;
    logic [3:0]    index;

    logic qualify;
    logic record_end;
    logic pop;
    logic push;
    logic drop;
    logic [71:0] record;

    // A full FIFO still accepts a push when the serializer pops on the same edge.
    always_comb begin
        qualify    = debug_reg_write_en && !(FILTER_ZERO && (debug_reg_write_addr == 5'd0));
        record_end = (state == SEND) && out_ready && (index == 4'd8);
        pop        = (fifo_count != '0) && ((state == IDLE) || record_end);
        push       = qualify && ((fifo_count != FIFO_FULL) || pop);
        drop       = qualify && !push;
        record     = {debug_pc_addr, 3'b000, debug_reg_write_addr, debug_reg_write_data};
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= record;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            drop_count <= 16'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
        end
    end

    // The head byte always sits in shreg[71:64]; each transfer shifts the next one up.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shreg <= 72'd0;
            index <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg <= mem[rd_ptr];
                        index <= 4'd0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (index == 4'd8) begin
                            if (pop) begin
                                shreg <= mem[rd_ptr];
                                index <= 4'd0;
                            end else begin
                                index <= 4'd0;
                                state <= IDLE;
                            end
                        end else begin
                            shreg <= shreg << 8;
                            index <= index + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        out_valid = (state == SEND);
        out_data  = (state == SEND) ? shreg[71:64] : 8'h00;
    end

endmodule

// File: tb/tb_trace_collector.sv
// Scoreboard bench for trace_collector: expected bytes are queued when events are
// driven and consumed by a monitor as the DUT transfers them.
module tb_trace_collector;

    logic        clk;
    logic        rst;
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
    logic        out_ready;

    logic        out_valid;
    logic [7:0]  out_data;
    logic        overflow;
    logic [15:0] drop_count;
    logic [3:0]  fifo_count;

    logic        nf_valid;
    logic [7:0]  nf_data;
    logic        nf_overflow;
    logic [15:0] nf_drop_count;
    logic [3:0]  nf_fifo_count;

    logic [7:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int xfer_cnt = 0;
    logic mon_en = 1'b0;

    trace_collector #(.DEPTH(8), .FILTER_ZERO(1'b1)) dut (
        .clk(clk), .rst(rst),
        .debug_reg_write_en(en), .debug_reg_write_addr(addr),
        .debug_reg_write_data(data), .debug_pc_addr(pc),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .overflow(overflow), .drop_count(drop_count), .fifo_count(fifo_count)
    );

    trace_collector #(.DEPTH(8), .FILTER_ZERO(1'b0)) dut_nf (
        .clk(clk), .rst(rst),
        .debug_reg_write_en(en), .debug_reg_write_addr(addr),
        .debug_reg_write_data(data), .debug_pc_addr(pc),
        .out_valid(nf_valid), .out_data(nf_data), .out_ready(out_ready),
        .overflow(nf_overflow), .drop_count(nf_drop_count), .fifo_count(nf_fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every byte accepted by the downstream side must match the scoreboard head.
    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            checks++;
            xfer_cnt++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_byte: got %02h, required no output", out_data);
            end else begin
                if (out_data !== exp_q[0]) begin
                    errors++;
                    $display("[TB] FAIL byte_order: got %02h, required %02h", out_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] byte_of(input logic [71:0] rec, input int i);
        logic [71:0] r;
        r = rec << (8 * i);
        return r[71:64];
    endfunction

    task automatic queue_record(input logic [31:0] p, input logic [4:0] a, input logic [31:0] d);
        logic [71:0] rec;
        rec = {p, 3'b000, a, d};
        for (int i = 0; i < 9; i++) exp_q.push_back(byte_of(rec, i));
    endtask

    task automatic send_event(input logic [31:0] p, input logic [4:0] a, input logic [31:0] d,
                              input bit expect_out);
        en   = 1'b1;
        pc   = p;
        addr = a;
        data = d;
        if (expect_out) queue_record(p, a, d);
        step();
        en = 1'b0;
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("[TB] FAIL drain_timeout: %0d bytes left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        do_reset();
        check_val("reset_valid", 32'(out_valid), 32'd0);
        check_val("reset_data", 32'(out_data), 32'h00);
        check_val("reset_fifo_count", 32'(fifo_count), 32'd0);
        check_val("reset_drop_count", 32'(drop_count), 32'd0);
        check_val("reset_overflow", 32'(overflow), 32'd0);
    endtask

    task automatic test_single_event();
        $display("[TB] test_single_event");
        out_ready = 1'b1;
        send_event(32'hBFC00004, 5'd8, 32'h12345678, 1'b1);
        check_val("latency_valid_edge_n", 32'(out_valid), 32'd0);
        check_val("latency_count_edge_n", 32'(fifo_count), 32'd1);
        step();
        check_val("latency_valid_edge_n1", 32'(out_valid), 32'd1);
        check_val("first_byte", 32'(out_data), 32'hBF);
        repeat (9) step();
        check_val("single_remaining", 32'(exp_q.size()), 32'd0);
        check_val("single_idle_valid", 32'(out_valid), 32'd0);
        check_val("single_idle_data", 32'(out_data), 32'h00);
    endtask

    task automatic test_filter();
        logic [71:0] rec;
        $display("[TB] test_filter");
        do_reset();
        out_ready = 1'b1;
        rec = {32'h00001000, 8'h00, 32'hCAFEF00D};
        send_event(32'h00001000, 5'd0, 32'hCAFEF00D, 1'b0);
        check_val("filter_fifo_count", 32'(fifo_count), 32'd0);
        check_val("nofilter_fifo_count", 32'(nf_fifo_count), 32'd1);
        step();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check_val("nofilter_valid", 32'(nf_valid), 32'd1);
            check_val("nofilter_byte", 32'(nf_data), 32'(byte_of(rec, i)));
        end
        step();
        check_val("nofilter_idle", 32'(nf_valid), 32'd0);
        check_val("filter_no_output", 32'(out_valid), 32'd0);
        check_val("filter_overflow", 32'(overflow), 32'd0);
    endtask

    task automatic test_backpressure();
        int valid_cycles = 0;
        logic held;
        logic [7:0] held_data;
        $display("[TB] test_backpressure");
        held = 1'b0;
        held_data = 8'h00;
        out_ready = 1'b1;
        send_event(32'h80000010, 5'd17, 32'hA5A55A5A, 1'b1);
        for (int i = 0; i < 24; i++) begin
            step();
            out_ready = ~out_ready;
            @(negedge clk);
            if (out_valid) valid_cycles++;
            if (held) check_val("hold_stable", 32'(out_data), 32'(held_data));
            held      = out_valid && !out_ready;
            held_data = out_data;
        end
        step();
        out_ready = 1'b1;
        check_val("bp_valid_cycles", 32'(valid_cycles), 32'd18);
        check_val("bp_remaining", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic test_back_to_back();
        $display("[TB] test_back_to_back");
        out_ready = 1'b1;
        send_event(32'h00000100, 5'd1, 32'h11111111, 1'b1);
        send_event(32'h00000104, 5'd2, 32'h22222222, 1'b1);
        send_event(32'h00000108, 5'd3, 32'h33333333, 1'b1);
        for (int i = 0; i < 26; i++) begin
            check_val("b2b_continuous_valid", 32'(out_valid), 32'd1);
            step();
        end
        check_val("b2b_end_valid", 32'(out_valid), 32'd0);
        check_val("b2b_remaining", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic test_overflow();
        int base;
        $display("[TB] test_overflow");
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            send_event(32'h00400000 + 32'(i * 4), 5'(i + 4), 32'hD0000000 + 32'(i), i < 9);
        end
        check_val("ovf_fifo_count", 32'(fifo_count), 32'd8);
        check_val("ovf_drop_count", 32'(drop_count), 32'd3);
        check_val("ovf_sticky", 32'(overflow), 32'd1);
        check_val("ovf_shreg_valid", 32'(out_valid), 32'd1);
        base = xfer_cnt;
        out_ready = 1'b1;
        wait_drain(150);
        check_val("ovf_total_bytes", 32'(xfer_cnt - base), 32'd81);
        check_val("ovf_still_sticky", 32'(overflow), 32'd1);
    endtask

    task automatic test_reset_mid_record();
        int base;
        int n = 0;
        $display("[TB] test_reset_mid_record");
        out_ready = 1'b1;
        base = xfer_cnt;
        send_event(32'h0000ABCD, 5'd9, 32'h87654321, 1'b1);
        while (xfer_cnt < base + 4 && n < 20) begin
            step();
            n++;
        end
        check_val("mid_bytes_before_reset", 32'(xfer_cnt - base), 32'd4);
        mon_en = 1'b0;
        exp_q.delete();
        rst  = 1'b1;
        en   = 1'b1;
        addr = 5'd5;
        pc   = 32'hDEAD0000;
        data = 32'hBEEF0000;
        step();
        rst = 1'b0;
        en  = 1'b0;
        mon_en = 1'b1;
        check_val("mid_valid", 32'(out_valid), 32'd0);
        check_val("mid_data", 32'(out_data), 32'h00);
        check_val("mid_fifo_count", 32'(fifo_count), 32'd0);
        check_val("mid_drop_count", 32'(drop_count), 32'd0);
        check_val("mid_overflow", 32'(overflow), 32'd0);
        base = xfer_cnt;
        repeat (15) step();
        check_val("mid_no_more_bytes", 32'(xfer_cnt - base), 32'd0);
        send_event(32'h00000200, 5'd31, 32'h0F0F0F0F, 1'b1);
        wait_drain(30);
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        addr      = 5'd0;
        data      = 32'd0;
        pc        = 32'd0;
        out_ready = 1'b1;
        test_reset();
        mon_en = 1'b1;
        test_single_event();
        test_filter();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_reset_mid_record();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
